// File: rtl/other_unit_seq.sv
// Registered "other" ALU sub-unit: single-cycle LUI/SLT/SLTU plus iterative
// CLZ/CLO that scans CLZ_STEP bits per cycle, MSB first, with early exit.
module other_unit_seq #(
   parameter int WIDTH     = 32,
   parameter int CLZ_STEP  = 4,
   parameter int IMM_SHIFT = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             ready_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             equal_o,
   output logic             small_o
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_LUI  = 3'b000;
   localparam logic [2:0] OP_SLT  = 3'b010;
   localparam logic [2:0] OP_SLTU = 3'b011;
   localparam logic [2:0] OP_CLZ  = 3'b100;
   localparam logic [2:0] OP_CLO  = 3'b101;

   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - CLZ_STEP);
   localparam logic [CW-1:0] STEP_CNT   = CW'(CLZ_STEP);

   typedef enum logic {
      S_IDLE,
      S_SCAN
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   shift_q;
   logic [CW-1:0]      count_q;
   logic               target_q;
   logic [WIDTH-1:0]   result_q;
   logic               equal_q;
   logic               small_q;
   logic               done_q;

   logic [CLZ_STEP-1:0] chunk_d;
   logic                hit_d;
   logic [CW-1:0]       hit_pos_d;
   logic                last_chunk_d;
   logic                slt_lt_d;
   logic                sltu_lt_d;
   logic                eq_d;
   logic [WIDTH-1:0]    lui_d;

   // Scan-chunk search: index of the first target bit, counted from the chunk MSB.
   always_comb begin
      chunk_d   = shift_q[WIDTH-1 -: CLZ_STEP];
      hit_d     = 1'b0;
      hit_pos_d = '0;
      for (int i = CLZ_STEP - 1; i >= 0; i--) begin
         if (!hit_d && (chunk_d[i] == target_q)) begin
            hit_d     = 1'b1;
            hit_pos_d = CW'(CLZ_STEP - 1 - i);
         end
      end
   end

   assign last_chunk_d = (count_q == LAST_COUNT);
   assign slt_lt_d     = ($signed(a_i) < $signed(b_i));
   assign sltu_lt_d    = (a_i < b_i);
   assign eq_d         = (a_i == b_i);
   assign lui_d        = b_i << IMM_SHIFT;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         count_q  <= '0;
         target_q <= 1'b0;
         result_q <= '0;
         equal_q  <= 1'b0;
         small_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  case (op_i)
                     OP_LUI: begin
                        result_q <= lui_d;
                        equal_q  <= 1'b0;
                        small_q  <= 1'b0;
                        done_q   <= 1'b1;
                     end
                     OP_SLT: begin
                        result_q <= WIDTH'(slt_lt_d);
                        equal_q  <= eq_d;
                        small_q  <= slt_lt_d;
                        done_q   <= 1'b1;
                     end
                     OP_SLTU: begin
                        result_q <= WIDTH'(sltu_lt_d);
                        equal_q  <= eq_d;
                        small_q  <= sltu_lt_d;
                        done_q   <= 1'b1;
                     end
                     OP_CLZ, OP_CLO: begin
                        // Operand is latched once; a_i is ignored for the rest of the scan.
                        shift_q  <= a_i;
                        count_q  <= '0;
                        target_q <= (op_i == OP_CLZ);
                        state_q  <= S_SCAN;
                     end
                     default: begin
                        result_q <= '0;
                        equal_q  <= 1'b0;
                        small_q  <= 1'b0;
                        done_q   <= 1'b1;
                     end
                  endcase
               end
            end
            S_SCAN: begin
               if (hit_d) begin
                  result_q <= WIDTH'(count_q + hit_pos_d);
                  equal_q  <= 1'b0;
                  small_q  <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= S_IDLE;
               end else if (last_chunk_d) begin
                  result_q <= WIDTH'(count_q + STEP_CNT);
                  equal_q  <= 1'b0;
                  small_q  <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= S_IDLE;
               end else begin
                  count_q <= count_q + STEP_CNT;
                  shift_q <= shift_q << CLZ_STEP;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ready_o  = (state_q == S_IDLE);
   assign done_o   = done_q;
   assign result_o = result_q;
   assign equal_o  = equal_q;
   assign small_o  = small_q;

endmodule
